reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Parametrised successor to the ID-stage register-address decode.
- Tracks outstanding register writes per architectural register, with multi-issue-safe counters.
- Raises an operand-hazard stall for the ID stage. Releases entries on one or more writeback ports, with optional same-cycle writeback bypass.
- Sits between ID decode (consumes read/write enables and addresses) and the pipeline control/stall logic.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= REG_NUM.
- READ_PORTS, 2, number of source operands checked per issue.
- WB_PORTS, 2, number of writeback ports releasing entries per cycle.
- CNT_W, 2, per-register outstanding-write counter width; maximum in flight is 2**CNT_W-1.
- WB_BYPASS, 1, 1 = a read is not stalled if every outstanding write to it retires this cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a valid instruction
- rd_en  in  READ_PORTS  per-port source-read enable
- rd_addr  in  READ_PORTS*ADDR_W  source addresses; port i at bits [i*ADDR_W +: ADDR_W]
- wr_en  in  1  instruction writes a destination
- wr_addr  in  ADDR_W  destination address
- wb_en  in  WB_PORTS  writeback-port valid
- wb_addr  in  WB_PORTS*ADDR_W  writeback addresses, packed as rd_addr
- flush  in  1  discard all tracking state
- stall  out  1  hazard: ID must hold
- issue_fire  out  1  instruction accepted this cycle
- pending_vec  out  REG_NUM  bit r = counter[r] != 0
- err_underflow  out  1  sticky: writeback to a register with counter 0

Behaviour:
- State: cnt[r] (CNT_W bits) for r = 1..REG_NUM-1; cnt[0] is constant 0. err_underflow is a flop.
- Reset (rst=1 at posedge): all cnt <= 0, err_underflow <= 0. While rst=1, stall=0 and issue_fire=0.
- wb_dec[r] = number of ports j with wb_en[j] and wb_addr[j]==r, excluding r==0. Range 0..WB_PORTS.
- Read hazard, port i: rd_en[i] and rd_addr[i]!=0 and cnt[a]!=0.
  - With WB_BYPASS=1, the hazard is cleared when wb_dec[a] >= cnt[a].
- Write hazard: wr_en and wr_addr!=0 and cnt[wr_addr]==all-ones (saturated).
  - Saturation is checked before same-cycle writeback: no bypass on the write side.
- stall = id_valid & ~rst & ~flush & (any read hazard | write hazard). Combinational, zero-cycle latency.
- issue_fire = id_valid & ~rst & ~flush & ~stall.
- Counter update at posedge, for each r != 0:
  - inc = issue_fire & wr_en & wr_addr==r.
  - next = cnt[r] + inc - wb_dec[r].
  - If cnt[r] + inc < wb_dec[r]: next = 0 and err_underflow <= 1.
- Simultaneous issue and writeback to the same register: net change +1-1 = 0.
- Writes to register 0: never counted, never stall.
- Writebacks to register 0: ignored, never underflow.
- flush=1 at posedge: all cnt <= 0; same-cycle issue and writebacks are ignored; err_underflow is kept.
  - Caller contract: flush is asserted only when no older write remains in flight.
  - rst has priority over flush.
- pending_vec is a registered view: reflects cnt after the last edge.
- err_underflow clears only on rst.
- Out-of-range addresses (>= REG_NUM) are treated as 0.

Decomposition:
- Shared package/include (alongside bus.v): REG_ADDR_BUS width macro, register-0 constant, default REG_NUM/ADDR_W.
- One natural sub-module, sb_counter_cell: a single register's counter.
  - Inputs: inc, dec count, flush.
  - Outputs: busy, saturated, underflow.
  - Instantiated REG_NUM-1 times by generate.
- Top-level holds hazard compare, writeback decode, and error flop.

Test Plan:
- Reset then id_valid=1, wr_en=1, wr_addr=8 -> issue_fire=1; next cycle pending_vec[8]=1, stall=0.
- cnt[8]=1; next instr rd_en=01, rd_addr[0]=8, no wb -> stall=1, issue_fire=0. Then wb_en=01, wb_addr=8:
  - WB_BYPASS=1 -> stall=0 same cycle.
  - WB_BYPASS=0 -> stall=1 that cycle, 0 the next.
- Issue three writes to r5 (CNT_W=2) -> cnt=3; fourth wr_addr=5 -> stall=1. Same cycle wb to r5 -> still stall=1; next cycle cnt=2, issue proceeds.
- Issue wr r9 with same-cycle wb r9 (cnt[9]=1) -> cnt[9] stays 1. Two wb ports both r9 with cnt=2 -> cnt=0.
- wb_en=01, wb_addr=4 with cnt[4]=0 -> err_underflow=1 next cycle, cnt[4]=0. Stays 1 after flush; clears only after rst.
- rd/wr to r0 with any cnt state -> never stall, pending_vec[0]=0. flush with cnt[3]=2 -> pending_vec=0 next cycle.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared register-address constants and scoreboard defaults
// Provides the default register count, address width and the hard-wired zero register index.
package reg_scoreboard_pkg;
    localparam int REG_NUM_DEF = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int REG_ZERO    = 0;
endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter_cell: outstanding-write counter for one architectural register
// Ports: clk, rst (sync, active-high), flush, inc (issue of a write), dec (writebacks this cycle),
//        cnt (current count), busy (cnt!=0), saturated (cnt all-ones), underflow (more retires than in flight).
module sb_counter_cell #(
    parameter int CNT_W = 2,
    parameter int DW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inc,
    input  logic [DW-1:0]    dec,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             saturated,
    output logic             underflow
);
    localparam int SW = CNT_W + DW + 1;
    logic [SW-1:0] sum;
    assign sum       = SW'(cnt) + SW'(inc);
    assign underflow = ~flush & (sum < SW'(dec));
    assign busy      = |cnt;
    assign saturated = &cnt;
    always_ff @(posedge clk) begin
        if (rst || flush) cnt <= '0;
        else cnt <= underflow ? '0 : CNT_W'(sum - SW'(dec));
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register outstanding-write tracking with operand-hazard stall for ID
// Ports: clk, rst (sync, active-high), id_valid, rd_en/rd_addr (source reads), wr_en/wr_addr (destination),
//        wb_en/wb_addr (writeback releases), flush; outputs stall, issue_fire, pending_vec, err_underflow (sticky).
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int REG_NUM    = REG_NUM_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int READ_PORTS = 2,
    parameter int WB_PORTS   = 2,
    parameter int CNT_W      = 2,
    parameter int WB_BYPASS  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [READ_PORTS-1:0]          rd_en,
    input  logic [READ_PORTS*ADDR_W-1:0]   rd_addr,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [WB_PORTS-1:0]            wb_en,
    input  logic [WB_PORTS*ADDR_W-1:0]     wb_addr,
    input  logic                           flush,
    output logic                           stall,
    output logic                           issue_fire,
    output logic [REG_NUM-1:0]             pending_vec,
    output logic                           err_underflow
);
    localparam int DW = $clog2(WB_PORTS + 1);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    // Addresses beyond the register file alias to the zero register.
    function automatic logic [ADDR_W-1:0] clip(input logic [ADDR_W-1:0] a);
        return (int'(a) < REG_NUM) ? a : ZERO;
    endfunction

    logic [ADDR_W-1:0]  rd_a [READ_PORTS];
    logic [ADDR_W-1:0]  wb_a [WB_PORTS];
    logic [ADDR_W-1:0]  wr_a;
    logic [DW-1:0]      wb_dec [REG_NUM];
    logic [CNT_W-1:0]   cnt [REG_NUM];
    logic [REG_NUM-1:0] busy, sat, uf;
    logic [READ_PORTS-1:0] rd_hz;
    logic               wr_hz, active;

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        assign rd_a[i] = clip(rd_addr[i*ADDR_W +: ADDR_W]);
    end
    for (genvar j = 0; j < WB_PORTS; j++) begin : g_wb
        assign wb_a[j] = clip(wb_addr[j*ADDR_W +: ADDR_W]);
    end
    assign wr_a = clip(wr_addr);

    always_comb begin
        for (int r = 0; r < REG_NUM; r++) wb_dec[r] = '0;
        for (int r = 1; r < REG_NUM; r++)
            for (int j = 0; j < WB_PORTS; j++)
                wb_dec[r] = wb_dec[r] + DW'(wb_en[j] && wb_a[j] == ADDR_W'(r));
    end

    // A read is released early only when this cycle's writebacks retire every outstanding write.
    always_comb begin
        rd_hz = '0;
        for (int i = 0; i < READ_PORTS; i++)
            rd_hz[i] = rd_en[i] && rd_a[i] != ZERO && busy[rd_a[i]] &&
                       !(WB_BYPASS != 0 && int'(wb_dec[rd_a[i]]) >= int'(cnt[rd_a[i]]));
    end

    // Saturation uses the pre-writeback count: the write side never bypasses.
    assign wr_hz      = wr_en && wr_a != ZERO && sat[wr_a];
    assign active     = id_valid & ~rst & ~flush;
    assign stall      = active & ((|rd_hz) | wr_hz);
    assign issue_fire = active & ~stall;
    assign pending_vec = busy;

    for (genvar g = 0; g < REG_NUM; g++) begin : g_cell
        if (g == REG_ZERO) begin : g_zero
            assign cnt[g]  = '0;
            assign busy[g] = 1'b0;
            assign sat[g]  = 1'b0;
            assign uf[g]   = 1'b0;
        end else begin : g_reg
            sb_counter_cell #(.CNT_W(CNT_W), .DW(DW)) u_cell (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .inc       (issue_fire & wr_en & (wr_a == ADDR_W'(g))),
                .dec       (wb_dec[g]),
                .cnt       (cnt[g]),
                .busy      (busy[g]),
                .saturated (sat[g]),
                .underflow (uf[g])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_underflow <= 1'b0;
        else if (|uf) err_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed checks of reg_scoreboard with and without writeback bypass
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst, id_valid, wr_en, flush;
    logic [1:0]  rd_en, wb_en;
    logic [9:0]  rd_addr, wb_addr;
    logic [4:0]  wr_addr;
    logic        stall, issue_fire, err_underflow;
    logic [31:0] pending_vec;
    logic        stall_nb, issue_fire_nb, err_underflow_nb;
    logic [31:0] pending_vec_nb;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.WB_BYPASS(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wb_en(wb_en), .wb_addr(wb_addr), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .pending_vec(pending_vec), .err_underflow(err_underflow)
    );

    reg_scoreboard #(.WB_BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wb_en(wb_en), .wb_addr(wb_addr), .flush(flush),
        .stall(stall_nb), .issue_fire(issue_fire_nb), .pending_vec(pending_vec_nb),
        .err_underflow(err_underflow_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; rd_en = 0; rd_addr = 0; wr_en = 0; wr_addr = 0; wb_en = 0; wb_addr = 0; flush = 0;
    endtask

    initial begin
        idle();
        rst = 1; id_valid = 1; wr_en = 1; wr_addr = 8;
        #1;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_fire", {31'd0, issue_fire}, 0);
        tick();
        chk("rst_pending", pending_vec, 0);
        chk("rst_err", {31'd0, err_underflow}, 0);
        rst = 0;
        #1;
        chk("wr8_fire", {31'd0, issue_fire}, 1);
        tick();
        idle();
        #1;
        chk("wr8_pending", pending_vec, 32'h100);
        chk("wr8_stall", {31'd0, stall}, 0);
        id_valid = 1; rd_en = 2'b01; rd_addr = {5'd0, 5'd8};
        #1;
        chk("raw8_stall", {31'd0, stall}, 1);
        chk("raw8_fire", {31'd0, issue_fire}, 0);
        chk("raw8_stall_nb", {31'd0, stall_nb}, 1);
        wb_en = 2'b01; wb_addr = {5'd0, 5'd8};
        #1;
        chk("byp8_stall", {31'd0, stall}, 0);
        chk("byp8_fire", {31'd0, issue_fire}, 1);
        chk("byp8_stall_nb", {31'd0, stall_nb}, 1);
        tick();
        wb_en = 0; wb_addr = 0;
        #1;
        chk("after8_pending", pending_vec, 0);
        chk("after8_stall_nb", {31'd0, stall_nb}, 0);
        idle();
        id_valid = 1; wr_en = 1; wr_addr = 5;
        for (int k = 0; k < 3; k++) tick();
        chk("sat5_pending", pending_vec, 32'h20);
        chk("sat5_stall", {31'd0, stall}, 1);
        wb_en = 2'b01; wb_addr = {5'd0, 5'd5};
        #1;
        chk("sat5_wb_stall", {31'd0, stall}, 1);
        chk("sat5_wb_fire", {31'd0, issue_fire}, 0);
        tick();
        wb_en = 0; wb_addr = 0;
        #1;
        chk("sat5_next_stall", {31'd0, stall}, 0);
        chk("sat5_next_fire", {31'd0, issue_fire}, 1);
        tick();
        idle();
        wb_en = 2'b11; wb_addr = {5'd5, 5'd5};
        tick();
        chk("drain5_one_left", pending_vec, 32'h20);
        wb_en = 2'b01;
        tick();
        chk("drain5_empty", pending_vec, 0);
        idle();
        id_valid = 1; wr_en = 1; wr_addr = 9;
        tick();
        wb_en = 2'b01; wb_addr = {5'd0, 5'd9};
        #1;
        chk("r9_same_fire", {31'd0, issue_fire}, 1);
        tick();
        chk("r9_net_zero", pending_vec, 32'h200);
        chk("r9_no_err", {31'd0, err_underflow}, 0);
        wb_en = 0; wb_addr = 0;
        tick();
        idle();
        wb_en = 2'b11; wb_addr = {5'd9, 5'd9};
        tick();
        chk("r9_dual_wb", pending_vec, 0);
        chk("r9_dual_err", {31'd0, err_underflow}, 0);
        idle();
        id_valid = 1; wr_en = 1; wr_addr = 3;
        tick();
        tick();
        idle();
        id_valid = 1; rd_en = 2'b11; rd_addr = 0; wr_en = 1; wr_addr = 0;
        wb_en = 2'b01; wb_addr = 0;
        #1;
        chk("r0_stall", {31'd0, stall}, 0);
        chk("r0_fire", {31'd0, issue_fire}, 1);
        tick();
        chk("r0_pending", pending_vec, 32'h8);
        chk("r0_wb_err", {31'd0, err_underflow}, 0);
        idle();
        id_valid = 1; rd_en = 2'b10; rd_addr = {5'd3, 5'd0}; wb_en = 2'b01; wb_addr = {5'd0, 5'd3};
        #1;
        chk("r3_port1_partial_wb", {31'd0, stall}, 1);
        idle();
        wb_en = 2'b01; wb_addr = {5'd0, 5'd4};
        tick();
        chk("uf4_err", {31'd0, err_underflow}, 1);
        chk("uf4_pending", pending_vec, 32'h8);
        idle();
        flush = 1; id_valid = 1; wr_en = 1; wr_addr = 7; wb_en = 2'b01; wb_addr = {5'd0, 5'd3};
        #1;
        chk("flush_stall", {31'd0, stall}, 0);
        chk("flush_fire", {31'd0, issue_fire}, 0);
        tick();
        idle();
        #1;
        chk("flush_pending", pending_vec, 0);
        chk("flush_err_kept", {31'd0, err_underflow}, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rst_err_clear", {31'd0, err_underflow}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
